// File: rtl/stack_ctrl_pkg.sv
// Shared sizing, vector map and encodings for the interrupt / return-address sequencer.
package stack_ctrl_pkg;
  localparam int NIRQ = 4;
  localparam int DEPTH = 15;
  localparam int IW = $clog2(NIRQ);
  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [9:0] VEC_BASE = 10'h3C0;
  localparam logic [9:0] VEC_STRIDE = 10'h010;

  typedef enum logic {ST_RUN = 1'b0, ST_FAULT = 1'b1} state_t;

  typedef enum logic [1:0] {
    FC_NONE = 2'b00,
    FC_OVF  = 2'b01,
    FC_UNF  = 2'b10,
    FC_MIS  = 2'b11
  } fcode_t;

  function automatic logic [9:0] vec_of(input logic [IW-1:0] idx);
    return VEC_BASE + 10'(VEC_STRIDE * 10'(idx));
  endfunction
endpackage

// File: rtl/stack_ctrl_if.sv
// Decode/config inputs and stack/PC command outputs of stack_ctrl.
interface stack_ctrl_if;
  import stack_ctrl_pkg::*;
  logic [NIRQ-1:0] irq;
  logic            call;
  logic            ret;
  logic            reti;
  logic            cfg_we;
  logic [NIRQ-1:0] cfg_mask;
  logic            stk_push;
  logic            stk_pop;
  logic            stk_irq_sel;
  logic            pc_vec;
  logic [9:0]      vec_addr;
  logic            kill;
  logic [NIRQ-1:0] in_service;
  logic [4:0]      depth;
  logic            fault;
  logic [1:0]      fault_code;

  modport slave (
    input  irq, call, ret, reti, cfg_we, cfg_mask,
    output stk_push, stk_pop, stk_irq_sel, pc_vec, vec_addr, kill,
           in_service, depth, fault, fault_code
  );
  modport master (
    output irq, call, ret, reti, cfg_we, cfg_mask,
    input  stk_push, stk_pop, stk_irq_sel, pc_vec, vec_addr, kill,
           in_service, depth, fault, fault_code
  );
endinterface

// File: rtl/stack_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder.
module prio_enc #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  output logic          o_vld,
  output logic [IW-1:0] o_idx
);
  always_comb begin
    o_vld = |i_req;
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (i_req[i]) o_idx = IW'(i);
  end
endmodule

// File: rtl/stack_ctrl.sv
// Interrupt arbitration, call/return sequencing and frame-type checking in front
// of the return-address stack. Any illegal stack use parks the block in FAULT.
module stack_ctrl
  import stack_ctrl_pkg::*;
(
  input logic       clk,
  input logic       reset,
  stack_ctrl_if.slave bus
);
  state_t          r_state, w_state_nx;
  fcode_t          r_code, w_fc;
  logic [NIRQ-1:0] r_irq_q, r_pend, r_mask, r_isv;
  logic [4:0]      r_depth;
  logic [DEPTH:0]  r_types;  // type bit of frame d at index d; index 0 unused

  logic [NIRQ-1:0] w_elig, w_clr, w_isv_nx;
  logic            w_vld, w_take, w_push, w_pop, w_type, w_kill;
  logic [IW-1:0]   w_win;
  logic [DW-1:0]   w_dnx;
  logic            w_top, w_full, w_empty, w_multi;

  // A source is blocked by any active handler of equal or higher priority.
  for (genvar g = 0; g < NIRQ; g++) begin : g_elig
    assign w_elig[g] = r_pend[g] & r_mask[g] & ~|r_isv[g:0];
  end

  prio_enc #(.N(NIRQ)) u_enc (.i_req(w_elig), .o_vld(w_vld), .o_idx(w_win));

  assign w_top   = r_types[r_depth[DW-1:0]];
  assign w_full  = (r_depth == 5'(DEPTH));
  assign w_empty = (r_depth == 5'd0);
  assign w_multi = (bus.call & bus.ret) | (bus.call & bus.reti) | (bus.ret & bus.reti);
  assign w_dnx   = r_depth[DW-1:0] + DW'(1);

  always_comb begin
    w_state_nx = r_state;
    w_fc       = FC_NONE;
    w_take     = 1'b0;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_type     = 1'b0;
    w_kill     = 1'b0;
    if (r_state == ST_RUN) begin
      if (w_vld) begin
        if (w_full) w_fc = FC_OVF;
        else begin
          w_take = 1'b1;
          w_push = 1'b1;
          w_type = 1'b1;
        end
      end else if (w_multi) begin
        w_fc = FC_MIS;
      end else if (bus.call) begin
        if (w_full) w_fc = FC_OVF;
        else        w_push = 1'b1;
      end else if (bus.ret | bus.reti) begin
        if (w_empty)                                     w_fc = FC_UNF;
        else if ((bus.ret & w_top) | (bus.reti & ~w_top)) w_fc = FC_MIS;
        else                                             w_pop = 1'b1;
      end
      w_kill = w_take | (w_fc != FC_NONE);
      if (w_fc != FC_NONE) w_state_nx = ST_FAULT;
    end else begin
      w_kill = 1'b1;
    end
    // Stack commands stay low through reset so the stack pointer can clear.
    if (reset) begin
      w_take = 1'b0;
      w_push = 1'b0;
      w_pop  = 1'b0;
      w_kill = 1'b0;
    end
  end

  assign w_clr = w_take ? (NIRQ'(1) << w_win) : '0;

  always_comb begin
    w_isv_nx = r_isv;
    if (w_take)              w_isv_nx = r_isv | w_clr;
    else if (w_pop & bus.reti) w_isv_nx = r_isv & (r_isv - NIRQ'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_code  <= FC_NONE;
      r_irq_q <= '0;
      r_pend  <= '0;
      r_mask  <= '0;
      r_isv   <= '0;
      r_depth <= '0;
      r_types <= '0;
    end else begin
      if (w_fc != FC_NONE) r_code <= w_fc;
      r_irq_q <= bus.irq;
      if (bus.cfg_we) r_mask <= bus.cfg_mask;
      r_pend <= (r_pend & ~w_clr) | (bus.irq & ~r_irq_q);
      r_isv  <= w_isv_nx;
      if (w_push) begin
        r_depth        <= r_depth + 5'd1;
        r_types[w_dnx] <= w_type;
      end else if (w_pop) begin
        r_depth <= r_depth - 5'd1;
      end
    end
  end

  assign bus.stk_push    = w_push;
  assign bus.stk_pop     = w_pop;
  assign bus.stk_irq_sel = w_pop & w_top;
  assign bus.pc_vec      = w_take;
  assign bus.vec_addr    = w_take ? vec_of(w_win) : 10'd0;
  assign bus.kill        = w_kill;
  assign bus.in_service  = r_isv;
  assign bus.depth       = r_depth;
  assign bus.fault       = (r_state == ST_FAULT);
  assign bus.fault_code  = r_code;
endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: directed vector table, corner sequences, random vs frame-queue model.
module tb_stack_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stack_ctrl_if bus();
  stack_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model: frames as a queue of type bits
  bit [3:0] m_irq_q, m_pend, m_mask, m_isv;
  bit       m_fault;
  bit [1:0] m_code;
  bit       m_ty[$];
  bit       e_push, e_pop, e_sel, e_pcv, e_kill, e_type;
  bit [9:0] e_vec;
  bit [1:0] e_fc;
  int       e_win;

  task automatic model_eval();
    int n;
    bit top;
    e_push = 0; e_pop = 0; e_sel = 0; e_pcv = 0; e_kill = 0; e_type = 0;
    e_vec = 0; e_fc = 0; e_win = -1;
    if (reset) return;
    if (m_fault) begin e_kill = 1; return; end
    for (int i = 0; i < 4; i++) begin
      int lowmask = (2 << i) - 1;
      if (e_win < 0 && m_pend[i] && m_mask[i] && ((int'(m_isv) & lowmask) == 0)) e_win = i;
    end
    if (e_win >= 0) begin
      if (m_ty.size() == 15) e_fc = 2'b01;
      else begin
        e_push = 1; e_pcv = 1; e_kill = 1; e_type = 1;
        e_vec = 10'(32'h3C0 + 16 * e_win);
      end
    end else begin
      n = int'(bus.call) + int'(bus.ret) + int'(bus.reti);
      if (n > 1) e_fc = 2'b11;
      else if (bus.call) begin
        if (m_ty.size() == 15) e_fc = 2'b01;
        else e_push = 1;
      end else if (bus.ret || bus.reti) begin
        if (m_ty.size() == 0) e_fc = 2'b10;
        else begin
          top = m_ty[$];
          if ((bus.ret && top) || (bus.reti && !top)) e_fc = 2'b11;
          else begin e_pop = 1; e_sel = top; end
        end
      end
    end
    if (e_fc != 0) e_kill = 1;
  endtask

  task automatic model_update();
    if (reset) begin
      m_irq_q = 0; m_pend = 0; m_mask = 0; m_isv = 0; m_fault = 0; m_code = 0;
      m_ty.delete();
      return;
    end
    if (!m_fault) begin
      if (e_fc != 0) begin m_fault = 1; m_code = e_fc; end
      else if (e_push) begin
        m_ty.push_back(e_type);
        if (e_win >= 0) begin m_isv[e_win] = 1; m_pend[e_win] = 0; end
      end else if (e_pop) begin
        void'(m_ty.pop_back());
        if (bus.reti)
          for (int i = 0; i < 4; i++) if (m_isv[i]) begin m_isv[i] = 0; break; end
      end
    end
    m_pend  = m_pend | (bus.irq & ~m_irq_q);
    m_irq_q = bus.irq;
    if (bus.cfg_we) m_mask = bus.cfg_mask;
  endtask

  function automatic logic [26:0] dut_out();
    return {bus.stk_push, bus.stk_pop, bus.stk_irq_sel, bus.pc_vec, bus.vec_addr, bus.kill,
            bus.in_service, bus.depth, bus.fault, bus.fault_code};
  endfunction

  function automatic logic [26:0] model_out();
    return {e_push, e_pop, e_sel, e_pcv, e_vec, e_kill, m_isv, 5'(m_ty.size()), m_fault, m_code};
  endfunction

  task automatic to_neg(); @(negedge clk); model_eval(); endtask
  task automatic to_pos(); @(posedge clk); model_update(); #1; endtask
  task automatic step(); to_neg(); to_pos(); endtask

  task automatic idle_in();
    bus.call = 0; bus.ret = 0; bus.reti = 0; bus.cfg_we = 0; bus.cfg_mask = 0; bus.irq = 0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1;
    to_neg(); chk("rst_cmds", dut_out(), model_out()); to_pos();
    reset = 0;
    to_neg(); chk("reset_state", dut_out(), 27'd0); to_pos();
  endtask

  // ---------------- directed vector table
  typedef struct {
    bit c, r, ri; bit [3:0] irq; bit we; bit [3:0] msk;
    bit push, pop, sel, pcv; bit [9:0] vec; bit kill; bit [3:0] isv; bit [4:0] dep;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t row(bit c, bit r, bit ri, bit [3:0] irq, bit we, bit [3:0] msk,
                               bit push, bit pop, bit sel, bit pcv, bit [9:0] vec, bit kill,
                               bit [3:0] isv, bit [4:0] dep);
    vec_t v;
    v.c = c; v.r = r; v.ri = ri; v.irq = irq; v.we = we; v.msk = msk;
    v.push = push; v.pop = pop; v.sel = sel; v.pcv = pcv; v.vec = vec; v.kill = kill;
    v.isv = isv; v.dep = dep;
    return v;
  endfunction

  initial begin
    idle_in();
    reset = 1;
    //                 c r ri irq    we msk     pu po se pv vec     k  isv     dep
    tbl.push_back(row(0,0,0,4'b0000,0,4'b0000, 0,0,0,0,10'h000,0,4'b0000,5'd0));
    tbl.push_back(row(1,0,0,4'b0000,0,4'b0000, 1,0,0,0,10'h000,0,4'b0000,5'd0));
    tbl.push_back(row(0,1,0,4'b0000,0,4'b0000, 0,1,0,0,10'h000,0,4'b0000,5'd1));
    tbl.push_back(row(0,0,0,4'b0000,0,4'b0000, 0,0,0,0,10'h000,0,4'b0000,5'd0));
    tbl.push_back(row(0,0,0,4'b0000,1,4'b0100, 0,0,0,0,10'h000,0,4'b0000,5'd0));
    tbl.push_back(row(0,0,0,4'b0100,0,4'b0000, 0,0,0,0,10'h000,0,4'b0000,5'd0));
    tbl.push_back(row(0,0,0,4'b0100,0,4'b0000, 1,0,0,1,10'h3E0,1,4'b0000,5'd0));
    tbl.push_back(row(0,0,0,4'b0000,0,4'b0000, 0,0,0,0,10'h000,0,4'b0100,5'd1));
    tbl.push_back(row(0,0,1,4'b0000,0,4'b0000, 0,1,1,0,10'h000,0,4'b0100,5'd1));
    tbl.push_back(row(0,0,0,4'b0000,0,4'b0000, 0,0,0,0,10'h000,0,4'b0000,5'd0));
    tbl.push_back(row(0,0,0,4'b0000,1,4'b1101, 0,0,0,0,10'h000,0,4'b0000,5'd0));
    tbl.push_back(row(0,0,0,4'b0100,0,4'b0000, 0,0,0,0,10'h000,0,4'b0000,5'd0));
    tbl.push_back(row(0,0,0,4'b0000,0,4'b0000, 1,0,0,1,10'h3E0,1,4'b0000,5'd0));
    tbl.push_back(row(0,0,0,4'b1000,0,4'b0000, 0,0,0,0,10'h000,0,4'b0100,5'd1));
    tbl.push_back(row(0,0,0,4'b0000,0,4'b0000, 0,0,0,0,10'h000,0,4'b0100,5'd1));
    tbl.push_back(row(0,0,0,4'b0001,0,4'b0000, 0,0,0,0,10'h000,0,4'b0100,5'd1));
    tbl.push_back(row(0,0,0,4'b0000,0,4'b0000, 1,0,0,1,10'h3C0,1,4'b0100,5'd1));
    tbl.push_back(row(0,0,1,4'b0000,0,4'b0000, 0,1,1,0,10'h000,0,4'b0101,5'd2));
    tbl.push_back(row(0,0,1,4'b0000,0,4'b0000, 0,1,1,0,10'h000,0,4'b0100,5'd1));
    tbl.push_back(row(0,0,0,4'b0000,0,4'b0000, 1,0,0,1,10'h3F0,1,4'b0000,5'd0));
    tbl.push_back(row(0,0,1,4'b0000,0,4'b0000, 0,1,1,0,10'h000,0,4'b1000,5'd1));
    tbl.push_back(row(0,0,0,4'b0000,0,4'b0000, 0,0,0,0,10'h000,0,4'b0000,5'd0));
    tbl.push_back(row(0,0,0,4'b0001,0,4'b0000, 0,0,0,0,10'h000,0,4'b0000,5'd0));
    tbl.push_back(row(1,0,0,4'b0000,0,4'b0000, 1,0,0,1,10'h3C0,1,4'b0000,5'd0));
    tbl.push_back(row(0,0,0,4'b0000,0,4'b0000, 0,0,0,0,10'h000,0,4'b0001,5'd1));
    tbl.push_back(row(0,0,1,4'b0000,0,4'b0000, 0,1,1,0,10'h000,0,4'b0001,5'd1));
    tbl.push_back(row(0,0,0,4'b0000,0,4'b0000, 0,0,0,0,10'h000,0,4'b0000,5'd0));

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    foreach (tbl[k]) begin
      bus.call = tbl[k].c; bus.ret = tbl[k].r; bus.reti = tbl[k].ri; bus.irq = tbl[k].irq;
      bus.cfg_we = tbl[k].we; bus.cfg_mask = tbl[k].msk;
      to_neg();
      chk($sformatf("tbl%0d", k), dut_out(),
          {tbl[k].push, tbl[k].pop, tbl[k].sel, tbl[k].pcv, tbl[k].vec, tbl[k].kill,
           tbl[k].isv, tbl[k].dep, 1'b0, 2'b00});
      to_pos();
    end

    // overflow: 15 calls fill the stack, the 16th faults without a push
    do_reset();
    bus.call = 1;
    for (int i = 0; i < 15; i++) begin
      to_neg(); chk($sformatf("ovf_call%0d", i), {bus.stk_push, bus.depth}, {1'b1, 5'(i)}); to_pos();
    end
    to_neg(); chk("ovf_16th", {bus.stk_push, bus.stk_pop, bus.kill}, 3'b001); to_pos();
    bus.irq = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      bus.call = i[0];
      bus.ret  = ~i[0];
      to_neg();
      chk("ovf_frozen", {bus.stk_push, bus.stk_pop, bus.pc_vec, bus.kill, bus.fault,
                         bus.fault_code, bus.depth}, {3'b000, 1'b1, 1'b1, 2'b01, 5'd15});
      to_pos();
    end

    // underflow
    do_reset();
    bus.ret = 1;
    to_neg(); chk("unf_cycle", {bus.stk_pop, bus.kill}, 2'b01); to_pos();
    bus.ret = 0;
    to_neg(); chk("unf_code", {bus.fault, bus.fault_code, bus.depth}, {1'b1, 2'b10, 5'd0}); to_pos();

    // ret on an interrupt frame
    do_reset();
    bus.cfg_we = 1; bus.cfg_mask = 4'b0010; step();
    bus.cfg_we = 0; bus.irq = 4'b0010; step();
    bus.irq = 0;
    to_neg(); chk("mis_take", {bus.stk_push, bus.pc_vec, bus.vec_addr}, {2'b11, 10'h3D0}); to_pos();
    bus.ret = 1;
    to_neg(); chk("mis_ret", {bus.stk_pop, bus.stk_irq_sel, bus.kill}, 3'b001); to_pos();
    bus.ret = 0;
    to_neg();
    chk("mis_code", {bus.fault, bus.fault_code, bus.depth, bus.in_service},
        {1'b1, 2'b11, 5'd1, 4'b0010});
    to_pos();

    // simultaneous decode ops
    do_reset();
    bus.call = 1; bus.ret = 1;
    to_neg(); chk("multi", {bus.stk_push, bus.stk_pop, bus.kill}, 3'b001); to_pos();
    idle_in();
    to_neg(); chk("multi_code", {bus.fault, bus.fault_code}, 3'b111); to_pos();

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 59) == 0) || (m_fault && ($urandom_range(0, 3) == 0));
      bus.call = ($urandom_range(0, 6) == 0);
      bus.ret  = ($urandom_range(0, 11) == 0);
      bus.reti = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) bus.irq[$urandom_range(0, 3)] = ~bus.irq[$urandom_range(0, 3)];
      bus.cfg_we   = ($urandom_range(0, 31) == 0);
      bus.cfg_mask = 4'($urandom_range(0, 15));
      to_neg(); chk($sformatf("rand%0d", c), dut_out(), model_out()); to_pos();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Interrupt and return-address sequencer for the single-cycle CPU. Sits between the control unit/decoder and the 16-entry return-address stack. Arbitrates four interrupt sources by fixed priority with priority-based nesting, issues push/pop and return-select commands to the stack, and redirects the PC to interrupt vectors. Tracks frame type and depth so `ret`/`reti` mismatches and stack over/underflow become a sticky fault, never a stack access.

## Interface
- `NIRQ`, 4: number of interrupt sources; index 0 is highest priority.
- `DEPTH`, 15: usable stack frames (entry 0 is never written).
- `VEC_BASE`, 10'h3C0: vector address of source 0.
- `VEC_STRIDE`, 10'h010: vector spacing; vector(i) = VEC_BASE + i*VEC_STRIDE, truncated to 10 bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `irq`  in  NIRQ  raw level request lines; rising edges are latched.
- `call`  in  1  decoded call this cycle.
- `ret`  in  1  decoded return-from-call this cycle.
- `reti`  in  1  decoded return-from-interrupt this cycle.
- `cfg_we`  in  1  mask write strobe.
- `cfg_mask`  in  NIRQ  enable mask value written on `cfg_we`.
- `stk_push`  out  1  push request to the stack.
- `stk_pop`  out  1  pop request to the stack.
- `stk_irq_sel`  out  1  return select: 1 returns the stored PC, 0 returns stored PC+1.
- `pc_vec`  out  1  PC mux selects `vec_addr` this cycle.
- `vec_addr`  out  10  vector of the source taken this cycle; 0 when `pc_vec`=0.
- `kill`  out  1  suppress side effects of the current instruction.
- `in_service`  out  NIRQ  active handler bits.
- `depth`  out  5  current frame count.
- `fault`  out  1  sticky fault.
- `fault_code`  out  2  01 overflow, 10 underflow, 11 frame-type mismatch, 00 none.

## Operation
- Edge detect: `irq_q` registers `irq`. `pending[i]` sets on `irq[i] & ~irq_q[i]` and clears when source i is taken. Set wins over clear in the same cycle.
- Eligibility:
  - Source i is eligible when `pending[i] & mask[i]` and no in-service bit of index <= i is set.
  - The lowest eligible index wins; this gives strict-priority nesting.
- Take:
  - `take`=1 if any source is eligible and the state is RUN.
  - On take, drive `stk_push`=1, `pc_vec`=1, `vec_addr`=vector(winner) and `kill`=1. `kill` means the current instruction is not executed; its PC is pushed.
  - Set `in_service[winner]`, clear `pending[winner]`, push type bit 1, increment `depth`.
  - `call`/`ret`/`reti` in a take cycle are ignored entirely.
- Call: push type bit 0, `stk_push`=1, increment `depth`.
- Ret / reti:
  - Either drives `stk_pop`=1 and decrements `depth`. `stk_irq_sel` = top type bit (combinational, same cycle).
  - `reti` also clears the lowest-index set in-service bit.
- Type shadow: a `DEPTH`-bit LIFO of frame types, indexed by `depth`.
- FSM states: RUN, FAULT.
  - RUN -> FAULT on any of:
    - push with `depth`==DEPTH: code 01.
    - `ret`/`reti` with `depth`==0: code 10.
    - `ret` on a type-1 frame, or `reti` on a type-0 frame: code 11.
  - The faulting cycle issues no push/pop and asserts `kill`.
  - FAULT: `stk_push`/`stk_pop`/`pc_vec` are forced 0, `kill`=1, `fault`=1. FAULT exits only on reset.
- Mask writes take effect the next cycle. Masking a pending source keeps it pending.
- More than one of `call`/`ret`/`reti` in one cycle is a mismatch fault (code 11).

## Timing
- Reset values:
  - State RUN; `pending`, `in_service`, `mask`, `irq_q`, `depth` all 0.
  - All outputs 0, `fault_code`=00.
  - During reset, `stk_push`/`stk_pop` are held 0 so the stack resets its pointer.
- Reset mid-handler discards all frames and in-service bits.
- Latency:
  - irq rising edge at cycle N -> pending at N+1 -> earliest take at N+1 (combinational).
  - Command outputs are combinational from current state and decode.
  - `depth`, `in_service` and the type LIFO update at the edge ending the command cycle.
- Return-select has zero latency: `stk_irq_sel` is valid in the same cycle as `stk_pop`.

## Structure
- A shared package/include holds `NIRQ`, `DEPTH`, `VEC_BASE`, `VEC_STRIDE`, the state encodings and the `fault_code` encodings.
- One sub-module: `prio_enc` (NIRQ-wide lowest-index priority encoder: valid and index).
- Type LIFO, edge detect and FSM live in `stack_ctrl`.

## Test plan
- Call 0x010, ret: `stk_push` then `stk_pop` with `stk_irq_sel`=0; `depth` 0->1->0.
- Pulse irq[2] with mask=4'b0100: take one cycle later, `vec_addr`=0x3E0, `kill`=1, `in_service`=0100. Then reti: `stk_irq_sel`=1, `in_service`=0000.
- In ISR 2, pulse irq[3] then irq[0]: irq[3] stays pending and irq[0] nests (`vec_addr`=0x3C0). After two retis, irq[3] is taken.
- irq edge coincident with `call`: only the interrupt push occurs, `depth`=1, call ignored.
- 15 calls then a 16th: `fault`=1, `fault_code`=01, no push issued, outputs frozen until reset.
- `ret` at depth 0 -> code 10; `ret` inside an ISR frame -> code 11; reset clears both to RUN with depth 0.
